mem_wb_stage: RTL

//  MIPS memory stage plus MEM/WB pipeline latch; consumes the EX/MEM latch outputs (ALU result, rt data, dest reg, mem/wb buses).

---
 rtl/mem_wb_stage_if.sv | 32 +++
 rtl/mem_wb_stage.sv | 67 ++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM inputs and MEM/WB latched outputs of the memory stage
interface mem_wb_stage_if #(
  parameter int len_data    = 32,
  parameter int num_bits    = 5,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2
);
  logic [len_data-1:0]    in_alu;
  logic [len_data-1:0]    in_reg2;
  logic [num_bits-1:0]    in_write_reg;
  logic                   in_zero_flag;
  logic [len_data-1:0]    in_pc_branch;
  logic                   in_halt_flag;
  logic [len_mem_bus-1:0] memory_bus;
  logic [len_wb_bus-1:0]  writeBack_bus;
  logic [len_data-1:0]    out_read_data;
  logic [len_data-1:0]    out_alu;
  logic [num_bits-1:0]    out_write_reg;
  logic [len_wb_bus-1:0]  writeBack_bus_out;
  logic                   out_halt_flag;
  logic                   pc_src;
  logic [len_data-1:0]    out_pc_branch;
  logic                   misalign_error;
  modport master (
    output in_alu, in_reg2, in_write_reg, in_zero_flag, in_pc_branch, in_halt_flag, memory_bus, writeBack_bus,
    input  out_read_data, out_alu, out_write_reg, writeBack_bus_out, out_halt_flag, pc_src, out_pc_branch, misalign_error
  );
  modport slave (
    input  in_alu, in_reg2, in_write_reg, in_zero_flag, in_pc_branch, in_halt_flag, memory_bus, writeBack_bus,
    output out_read_data, out_alu, out_write_reg, writeBack_bus_out, out_halt_flag, pc_src, out_pc_branch, misalign_error
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory stage with byte-lane data memory, branch resolve and MEM/WB latch
module mem_wb_stage #(
  parameter int len_data    = 32,
  parameter int num_bits    = 5,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int mem_depth   = 256,
  localparam int aw         = $clog2(mem_depth)
) (
  input  logic                clk,
  input  logic                reset,
  mem_wb_stage_if.slave       bus,
  input  logic [aw-1:0]       dbg_addr,
  output logic [len_data-1:0] dbg_data
);
  logic [31:0] mem [mem_depth];
  logic [aw-1:0] idx;
  logic [1:0] off, sz;
  logic uns, rd, wr, beq, bne, mis;
  logic [31:0] word, shifted, ext, ld_val, wd, mask;
  logic [15:0] hw;
  logic [3:0] be;
  logic unused_bits;
  assign unused_bits = ^bus.memory_bus[len_mem_bus-1:7];
  always_comb begin
    idx     = bus.in_alu[aw+1:2];
    off     = bus.in_alu[1:0];
    sz      = bus.memory_bus[1:0];
    uns     = bus.memory_bus[2];
    rd      = bus.memory_bus[3];
    wr      = bus.memory_bus[4];
    beq     = bus.memory_bus[5];
    bne     = bus.memory_bus[6];
    mis     = (rd | wr) & ((sz == 2'b10) | ((sz == 2'b01) & off[0]) | ((sz == 2'b11) & (off != 2'b00)));
    word    = mem[idx];
    shifted = word >> {off, 3'b000};
    hw      = off[1] ? word[31:16] : word[15:0];
    ext     = sz == 2'b00 ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
              sz == 2'b01 ? {{16{~uns & hw[15]}}, hw} : word;
    ld_val  = (rd & ~wr & ~mis) ? ext : 32'h0;
    be      = sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wd      = sz == 2'b00 ? {4{bus.in_reg2[7:0]}} : sz == 2'b01 ? {2{bus.in_reg2[15:0]}} : bus.in_reg2;
    bus.pc_src        = (beq & ~bne & bus.in_zero_flag) | (bne & ~beq & ~bus.in_zero_flag);
    bus.out_pc_branch = bus.in_pc_branch;
    dbg_data          = mem[dbg_addr];
  end
  // memory is not reset so its contents survive a pipeline flush
  always_ff @(negedge clk) if (wr & ~mis) mem[idx] <= (word & ~mask) | (wd & mask);
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_read_data     <= '0;
      bus.out_alu           <= '0;
      bus.out_write_reg     <= '0;
      bus.writeBack_bus_out <= '0;
      bus.out_halt_flag     <= 1'b0;
      bus.misalign_error    <= 1'b0;
    end else begin
      bus.out_read_data     <= ld_val;
      bus.out_alu           <= bus.in_alu;
      bus.out_write_reg     <= bus.in_write_reg;
      bus.writeBack_bus_out <= {bus.writeBack_bus[1] & ~mis, bus.writeBack_bus[0]};
      bus.out_halt_flag     <= bus.in_halt_flag;
      bus.misalign_error    <= bus.misalign_error | mis;
    end
  end
endmodule
